// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state encoding,
// parity mode values and bit-period counter sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic int cntWidth(input int clksPerBit);
        return (clksPerBit <= 2) ? 1 : $clog2(clksPerBit);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Serial line conditioning: 2-FF synchroniser followed by a majority vote over
// the samples at MID-1, MID and MID+1 of the current bit period.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 435,
    parameter int CW           = cntWidth(CLKS_PER_BIT)
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    input  logic          i_Rx_Serial,
    input  logic [CW-1:0] cnt_i,
    input  logic          sample_en_i,
    output logic          line_o,
    output logic          vote_o
);

    localparam int MID = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] POS_EARLY = CW'(MID - 1);
    localparam logic [CW-1:0] POS_MID   = CW'(MID);

    logic       rx_meta_q;
    logic       rx_sync_q;
    logic [1:0] samples_q;
    logic [1:0] samples_d;

    // The sample window holds the MID-1 and MID samples; the live synchronised
    // value supplies the third sample, so the vote is ready during the MID+1 cycle.
    always_comb begin
        samples_d = samples_q;
        if (sample_en_i && ((cnt_i == POS_EARLY) || (cnt_i == POS_MID))) begin
            samples_d = {samples_q[0], rx_sync_q};
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            samples_q <= 2'b11;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_sync_q <= rx_meta_q;
            samples_q <= samples_d;
        end
    end

    assign line_o = rx_sync_q;
    assign vote_o = (samples_q[1] & samples_q[0]) |
                    (samples_q[1] & rx_sync_q)    |
                    (samples_q[0] & rx_sync_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with voting, framing/break/overrun detection and a
// ready/valid output register. Define UART_RX_PARITY_EN to add a checked parity bit.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 435,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Parity_Odd,
    input  logic                 i_Rx_Ready,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Overrun,
    output logic                 o_Break
);

    localparam int CW  = cntWidth(CLKS_PER_BIT);
    localparam int MID = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] CNT_MAX     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(MID + 1);
    localparam logic [3:0]    LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP   = 4'(STOP_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_err_q, stop_err_d;
    logic                 stop_hi_q, stop_hi_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 dv_q, dv_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;
    logic                 brk_q, brk_d;

    logic line, vote, at_centre, sample_en;
    logic frame_err, parity_err, par_zero, is_break;

    assign sample_en = (state_q != ST_IDLE) && (state_q != ST_BRK_WAIT);
    assign at_centre = (cnt_q == SAMPLE_LAST);

    uart_rx_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CW           (CW)
    ) u_sampler (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (i_Rx_Serial),
        .cnt_i       (cnt_q),
        .sample_en_i (sample_en),
        .line_o      (line),
        .vote_o      (vote)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, par_bit_d;
    assign parity_err = ((par_bit_q ^ (^shift_q)) != (i_Parity_Odd == PARITY_ODD));
    assign par_zero   = ~par_bit_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = i_Parity_Odd;
    assign parity_err = 1'b0;
    assign par_zero   = 1'b1;
`endif

    assign frame_err = stop_err_q | ~vote;
    assign is_break  = (shift_q == '0) && par_zero && !stop_hi_q && !vote;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        stop_err_d = stop_err_q;
        stop_hi_d  = stop_hi_q;
        byte_d     = byte_q;
        dv_d       = dv_q && !i_Rx_Ready;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        ovr_d      = 1'b0;
        brk_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!line) state_d = ST_START;
            end
            ST_START: begin
                if (at_centre) begin
                    stop_err_d = 1'b0;
                    stop_hi_d  = 1'b0;
                    state_d    = vote ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_centre) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_centre) begin
                    par_bit_d = vote;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (at_centre) begin
                    if (vote) stop_hi_d = 1'b1;
                    else      stop_err_d = 1'b1;
                    if (bit_idx_q == LAST_STOP) begin
                        // Finishing at the stop-bit centre leaves half a bit to spot the next start edge.
                        bit_idx_d = '0;
                        state_d   = ST_IDLE;
                        if (is_break) begin
                            brk_d   = 1'b1;
                            state_d = ST_BRK_WAIT;
                        end else if (!dv_q || i_Rx_Ready) begin
                            byte_d = shift_q;
                            dv_d   = 1'b1;
                            ferr_d = frame_err;
                            perr_d = parity_err;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_BRK_WAIT: begin
                cnt_d = '0;
                if (line) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            stop_err_q <= 1'b0;
            stop_hi_q  <= 1'b0;
            byte_q     <= '0;
            dv_q       <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            stop_err_q <= stop_err_d;
            stop_hi_q  <= stop_hi_d;
            byte_q     <= byte_d;
            dv_q       <= dv_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign o_Rx_DV      = dv_q;
    assign o_Rx_Byte    = byte_q;
    assign o_Frame_Err  = ferr_q;
    assign o_Parity_Err = perr_q;
    assign o_Overrun    = ovr_q;
    assign o_Break      = brk_q;

endmodule
